// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state and port encodings shared by the memory port arbiter
package mem_port_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN0 = 2'd1;
  localparam logic [1:0] ARB_OWN1 = 2'd2;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  function automatic logic [1:0] own_state(input logic port);
    return port ? ARB_OWN1 : ARB_OWN0;
  endfunction
endpackage

// File: rtl/arb_lock_timer.sv
// arb_lock_timer: counts consecutive locked transfers and forces release at LOCK_MAX
module arb_lock_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic locked_xfer,
  input  logic release_own,
  output logic force_rel,
  output logic lock_err
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt;
  assign force_rel = locked_xfer && lock_cnt == CW'(LOCK_MAX - 1);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_cnt <= release_own ? '0 : lock_cnt + CW'(locked_xfer);
      lock_err <= force_rel;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter with lock for the shared synchronous memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err
);
  logic [1:0] state, state_nx;
  logic prio, own0, own1, own_req, own_lock, locked_xfer, force_rel, rel;
  // ownership is masked during reset so no grant or write escapes the reset cycle
  assign own0 = resetn && state == ARB_OWN0;
  assign own1 = resetn && state == ARB_OWN1;
  assign m0_gnt = own0 && m0_req;
  assign m1_gnt = own1 && m1_req;
  assign own_req = own0 ? m0_req : m1_req;
  assign own_lock = own0 ? m0_lock : m1_lock;
  assign locked_xfer = (m0_gnt && m0_lock) || (m1_gnt && m1_lock);
  assign rel = (own0 || own1) && (!own_req || !own_lock || force_rel);
  assign mem_addr = own0 ? m0_addr : own1 ? m1_addr : '0;
  assign mem_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign mem_be = own0 ? m0_be : own1 ? m1_be : '0;
  assign mem_we = (m0_gnt && m0_we) || (m1_gnt && m1_we);
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;
  assign state_nx = state == ARB_IDLE ? (m0_req && m1_req ? own_state(prio) :
                                         m0_req ? ARB_OWN0 : m1_req ? ARB_OWN1 : ARB_IDLE)
                  : !(own0 || own1) ? ARB_IDLE
                  : !rel ? state
                  : own0 ? (m1_req ? ARB_OWN1 : ARB_IDLE) : (m0_req ? ARB_OWN0 : ARB_IDLE);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      prio <= PORT0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      state <= state_nx;
      if (rel) prio <= own0 ? PORT1 : PORT0;
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
    end
  end
  arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock (
    .clk(clk),
    .resetn(resetn),
    .locked_xfer(locked_xfer),
    .release_own(rel),
    .force_rel(force_rel),
    .lock_err(lock_err)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench with a small synchronous memory model
module tb_mem_port_arbiter;
  logic clk = 1'b0, resetn;
  logic m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m0_be, m1_be, mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_we, lock_err;
  logic [31:0] mem [0:255] = '{64: 32'hDEADBEEF, 128: 32'h11223344, default: 32'h0};
  int passed = 0, total = 0;

  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic lock);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_lock = lock;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic lock);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_lock = lock;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_lock_err", lock_err, 0);
    // single read by port 0
    resetn = 1'b1;
    drive0(1, 0, 32'h100, 0, 4'hF, 0);
    #1;
    chk("rd_idle_gnt", m0_gnt, 0);
    tick();
    chk("rd_gnt", m0_gnt, 1);
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_m1_gnt", m1_gnt, 0);
    tick();
    drive0(0, 0, 32'h100, 0, 4'hF, 0);
    #1;
    chk("rd_rvalid", m0_rvalid, 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_gnt_off", m0_gnt, 0);
    tick();
    chk("rd_rvalid_off", m0_rvalid, 0);
    chk("rd_idle_addr", mem_addr, 0);
    // prio now 1: simultaneous request goes to m1 first, then hands over to m0
    drive0(1, 0, 32'h100, 0, 4'hF, 0);
    drive1(1, 0, 32'h200, 0, 4'hF, 0);
    tick();
    chk("p1_m1_gnt", m1_gnt, 1);
    chk("p1_m0_gnt", m0_gnt, 0);
    chk("p1_addr", mem_addr, 32'h200);
    tick();
    drive1(0, 0, 0, 0, 0, 0);
    #1;
    chk("ho_m0_gnt", m0_gnt, 1);
    chk("ho_m1_gnt", m1_gnt, 0);
    chk("ho_m1_rvalid", m1_rvalid, 1);
    chk("ho_m1_rdata", m1_rdata, 32'h11223344);
    chk("ho_addr", mem_addr, 32'h100);
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    #1;
    chk("ho_m0_rvalid", m0_rvalid, 1);
    chk("ho_m0_rdata", m0_rdata, 32'hDEADBEEF);
    // prio 0 after reset: m0 first, direct hand-over to m1
    do_reset();
    drive0(1, 0, 32'h100, 0, 4'hF, 0);
    drive1(1, 0, 32'h200, 0, 4'hF, 0);
    #1;
    chk("p0_idle_gnt", {m0_gnt, m1_gnt}, 0);
    tick();
    chk("p0_m0_gnt", m0_gnt, 1);
    chk("p0_m1_gnt", m1_gnt, 0);
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    #1;
    chk("p0_ho_m1_gnt", m1_gnt, 1);
    chk("p0_ho_m0_gnt", m0_gnt, 0);
    tick();
    drive1(0, 0, 0, 0, 0, 0);
    tick();
    // locked read-modify-write by m0 while m1 waits
    drive0(1, 0, 32'h200, 0, 4'hF, 1);
    drive1(1, 0, 32'h100, 0, 4'hF, 0);
    tick();
    chk("rmw_rd_gnt", m0_gnt, 1);
    chk("rmw_rd_m1", m1_gnt, 0);
    tick();
    drive0(1, 1, 32'h200, 32'h0000AB00, 4'b0010, 0);
    #1;
    chk("rmw_wr_gnt", m0_gnt, 1);
    chk("rmw_wr_m1", m1_gnt, 0);
    chk("rmw_rvalid", m0_rvalid, 1);
    chk("rmw_rdata", m0_rdata, 32'h11223344);
    chk("rmw_mem_we", mem_we, 1);
    chk("rmw_mem_be", mem_be, 4'b0010);
    chk("rmw_wdata", mem_wdata, 32'h0000AB00);
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    #1;
    chk("rmw_m1_gnt", m1_gnt, 1);
    chk("rmw_m0_gnt", m0_gnt, 0);
    chk("rmw_no_rvalid", m0_rvalid, 0);
    tick();
    drive1(0, 0, 0, 0, 0, 0);
    drive0(1, 0, 32'h200, 0, 4'hF, 0);
    #1;
    tick();
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    #1;
    chk("rmw_rb_rvalid", m0_rvalid, 1);
    chk("rmw_rb_rdata", m0_rdata, 32'h1122AB44);
    tick();
    // lock watchdog: m1 holds lock continuously while m0 waits
    do_reset();
    drive1(1, 0, 32'h100, 0, 4'hF, 1);
    #1;
    tick();
    drive0(1, 0, 32'h200, 0, 4'hF, 0);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wd_gnt%0d", i), {m1_gnt, m0_gnt}, 2'b10);
      chk($sformatf("wd_err%0d", i), lock_err, 0);
      tick();
    end
    drive1(0, 0, 0, 0, 0, 0);
    #1;
    chk("wd_m1_off", m1_gnt, 0);
    chk("wd_m0_gnt", m0_gnt, 1);
    chk("wd_lock_err", lock_err, 1);
    tick();
    chk("wd_err_pulse", lock_err, 0);
    chk("wd_m0_rvalid", m0_rvalid, 1);
    drive0(0, 0, 0, 0, 0, 0);
    tick();
    // owner drops req while locked after two transfers
    drive0(1, 0, 32'h100, 0, 4'hF, 1);
    #1;
    tick();
    tick();
    tick();
    chk("drop_cnt2", 32'(dut.u_lock.lock_cnt), 2);
    m0_req = 1'b0;
    #1;
    chk("drop_gnt", m0_gnt, 0);
    chk("drop_owned_addr", mem_addr, 32'h100);
    tick();
    chk("drop_idle_addr", mem_addr, 0);
    chk("drop_cnt0", 32'(dut.u_lock.lock_cnt), 0);
    chk("drop_err", lock_err, 0);
    drive0(0, 0, 0, 0, 0, 0);
    tick();
    // reset during an owned write: the write must not reach memory
    drive0(1, 1, 32'h300, 32'h55, 4'hF, 0);
    #1;
    tick();
    chk("rw_we_pre", mem_we, 1);
    resetn = 1'b0;
    #1;
    chk("rw_we_rst", mem_we, 0);
    chk("rw_gnt_rst", m0_gnt, 0);
    tick();
    resetn = 1'b1;
    drive0(0, 0, 0, 0, 0, 0);
    // reset during an m1 read grant suppresses its rvalid
    drive1(1, 0, 32'h200, 0, 4'hF, 0);
    #1;
    tick();
    chk("rr_gnt", m1_gnt, 1);
    resetn = 1'b0;
    #1;
    chk("rr_gnt_rst", m1_gnt, 0);
    tick();
    resetn = 1'b1;
    drive1(0, 0, 0, 0, 0, 0);
    #1;
    chk("rr_rvalid", m1_rvalid, 0);
    chk("rr_gnts", {m0_gnt, m1_gnt}, 0);
    chk("rr_mem", {mem_we, mem_be}, 0);
    chk("rr_addr", mem_addr, 0);
    chk("rr_wdata", mem_wdata, 0);
    chk("rr_err", lock_err, 0);
    tick();
    chk("rr_rvalid2", {m0_rvalid, m1_rvalid}, 0);
    chk("rr_mem_unwritten", mem[8'hC0], 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
